sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Pixel-rendering stage that sits directly downstream of the game controller. At each frame start it snapshots the controller's outputs: game state, player and enemy position, HP, shield and squat flags, and both bullets. It then turns each incoming VGA pixel coordinate into a 24-bit RGB value using fixed layer priority. Output goes straight to the VGA DAC interface, 2 cycles after the coordinate.

## Interface
Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- CHAR_W, 64, character sprite width
- CHAR_H, 96, character sprite height (standing)
- BULLET_W, 16, bullet width
- BULLET_H, 8, bullet height

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_frame_start  in  1  one-cycle pulse at start of vertical blank
- i_pix_valid  in  1  pixel coordinate valid this cycle
- i_pix_x  in  11  pixel column, unsigned
- i_pix_y  in  10  pixel row, unsigned
- i_state  in  2  game state (START=0, PLAY=1, WIN=2, LOSE=3)
- i_player_x / i_enemy_x  in  11 signed  sprite top-left x
- i_player_y / i_enemy_y  in  10 signed  sprite top-left y
- i_player_hp / i_enemy_hp  in  2  hit points 0..3
- i_player_shield / i_enemy_shield  in  1  shield active
- i_player_squat / i_enemy_squat  in  1  squatting
- i_goodbullet_x / i_badbullet_x  in  11 signed  bullet top-left x
- i_goodbullet_y / i_badbullet_y  in  10 signed  bullet top-left y
- i_goodbullet_isE / i_badbullet_isE  in  1  bullet exists
- o_valid  out  1  RGB valid
- o_r, o_g, o_b  out  8 each  pixel colour
- o_layer  out  3  winning layer ID (0=bg, 1=HUD, 2=enemy, 3=player, 4=shield, 5=badbullet, 6=goodbullet)

## Operation
- Snapshot registers hold every i_* game input.
  - Loaded only on the cycle i_frame_start=1.
  - Held for the rest of the frame, so the frame never tears.
- Non-PLAY snapshot state: the whole screen is a flat colour.
  - START: 0x0000C0.
  - WIN: 0x00C000.
  - LOSE: 0xC00000.
  - o_layer=0.
- PLAY state uses layers. Highest priority wins.
  - Good bullet: 0xFFFF00, only when isE=1.
  - Bad bullet: 0xFF00FF, only when isE=1.
  - Shield: the 4-pixel inner border of a character box whose shield=1. Colour 0x00FFFF.
  - Player body: 0x2060FF.
  - Enemy body: 0xFF4020.
  - HUD.
  - Background: 0x202020.
- Character box:
  - Columns sx..sx+CHAR_W-1.
  - Rows sy..sy+CHAR_H-1 when standing.
  - Rows sy+CHAR_H/2..sy+CHAR_H-1 when squat=1.
- Hit test:
  - Compute dx = pix − sprite origin in 12-bit signed arithmetic (sign-extend both operands).
  - Hit iff 0 ≤ dx < W and 0 ≤ dy < H.
  - Sprites partially or fully off-screen (negative or > SCREEN_W) clip correctly. There is never a wrap-around hit.
- When i_pix_valid=0, the pipeline advances with valid=0. RGB outputs are then forced to 0.

## Timing
- Latency is exactly 2 cycles.
  - Stage 1 registers the coordinate plus all hit flags.
  - Stage 2 registers the priority-resolved colour and layer.
  - Throughput is 1 pixel/cycle, with no stalls.
- i_frame_start and i_pix_valid asserted in the same cycle: that pixel uses the old snapshot. The new snapshot applies from the next cycle.
- Reset values:
  - All outputs are 0.
  - Snapshot is cleared to 0, so state=START and HP=0.
  - Both pipeline valid bits are 0.
- Reset mid-frame: outputs drop to 0 immediately. Rendering resumes with the START colour until the next i_frame_start.

## Configuration
- HUD_HP_BAR_EN defined: HP bars are drawn in PLAY state.
  - Player bar: x = 16 .. 16+32·hp−1, y = 8..15, colour 0x00FF00.
  - Enemy bar: x = SCREEN_W−16−32·hp .. SCREEN_W−17, same rows, colour 0xFF0000.
  - hp=0 draws no bar.
- HUD_HP_BAR_EN undefined: no HUD logic. Layer 1 is never produced.

## Structure
- game_pkg additions:
  - State encoding constants.
  - 24-bit colour constants.
  - Layer ID enum.
  - Snapshot struct typedef.
- Sub-module box_hit:
  - Combinational signed rectangle test.
  - Inputs: pix_x, pix_y, origin x/y, width, height.
  - Output: hit.
  - Instantiated once per sprite.

## Test plan
- Reset, then frame_start with state=START, then pixel (0,0) valid → 2 cycles later o_valid=1, RGB=0x0000C0, layer=0.
- PLAY, player at (100,200), standing, no shield; pixels (100,200) and (163,295) → 0x2060FF, layer 3. Pixels (164,200) and (100,296) → background 0x202020.
- Player squat=1 at (100,200): pixel (120,220) → background; pixel (120,250) → player colour. With shield=1: pixel (101,250) → 0x00FFFF, layer 4.
- Good bullet isE=1 at (110,210) overlapping player → pixel (112,212) gives 0xFFFF00, layer 6. Bullet at x=−8: pixel (0,210) → hit; pixel (639,210) → no hit.
- Change player_x mid-frame without frame_start → rendered position unchanged. After frame_start → new position. Same-cycle frame_start + pixel → that pixel uses the old snapshot.
- With HUD_HP_BAR_EN, player_hp=2: pixel (79,10) → 0x00FF00, pixel (80,10) → background. Without the macro: pixel (20,10) → background.

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// Shared types and constants for the sprite compositor.
//   - game state encoding, layer IDs, 24-bit colours
//   - per-frame snapshot struct of the game controller outputs
//   - sign-extension helpers for sprite origins
package sprite_compositor_pkg;

    typedef enum logic [1:0] {
        StStart = 2'd0,
        StPlay  = 2'd1,
        StWin   = 2'd2,
        StLose  = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        LayerBg         = 3'd0,
        LayerHud        = 3'd1,
        LayerEnemy      = 3'd2,
        LayerPlayer     = 3'd3,
        LayerShield     = 3'd4,
        LayerBadBullet  = 3'd5,
        LayerGoodBullet = 3'd6
    } layer_e;

    localparam logic [23:0] COL_START  = 24'h0000C0;
    localparam logic [23:0] COL_WIN    = 24'h00C000;
    localparam logic [23:0] COL_LOSE   = 24'hC00000;
    localparam logic [23:0] COL_GOOD   = 24'hFFFF00;
    localparam logic [23:0] COL_BAD    = 24'hFF00FF;
    localparam logic [23:0] COL_SHIELD = 24'h00FFFF;
    localparam logic [23:0] COL_PLAYER = 24'h2060FF;
    localparam logic [23:0] COL_ENEMY  = 24'hFF4020;
    localparam logic [23:0] COL_HUD_P  = 24'h00FF00;
    localparam logic [23:0] COL_HUD_E  = 24'hFF0000;
    localparam logic [23:0] COL_BG     = 24'h202020;

    // Shield ring thickness, measured inward from the character box edge.
    localparam int unsigned SHIELD_T = 4;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  hp;
        logic        shield;
        logic        squat;
    } char_snap_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        ise;
    } bullet_snap_t;

    typedef struct packed {
        game_state_e  state;
        char_snap_t   player;
        char_snap_t   enemy;
        bullet_snap_t good;
        bullet_snap_t bad;
    } snapshot_t;

    function automatic logic [11:0] sext_x(input logic [10:0] v);
        return {v[10], v};
    endfunction

    function automatic logic [11:0] sext_y(input logic [9:0] v);
        return {{2{v[9]}}, v};
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream bundle between the VGA timing source, the compositor and the DAC.
//   i_pix_valid/i_pix_x/i_pix_y : coordinate in (master drives, slave consumes)
//   o_valid/o_r/o_g/o_b/o_layer : resolved colour out (slave drives)
interface sprite_compositor_if;
    logic        i_pix_valid;
    logic [10:0] i_pix_x;
    logic [9:0]  i_pix_y;
    logic        o_valid;
    logic [7:0]  o_r;
    logic [7:0]  o_g;
    logic [7:0]  o_b;
    logic [2:0]  o_layer;

    modport master (
        output i_pix_valid, i_pix_x, i_pix_y,
        input  o_valid, o_r, o_g, o_b, o_layer
    );

    modport slave (
        input  i_pix_valid, i_pix_x, i_pix_y,
        output o_valid, o_r, o_g, o_b, o_layer
    );
endinterface

// File: rtl/sprite_compositor_box_hit.sv
// box_hit: combinational signed rectangle test.
//   i_pix_x/i_pix_y   : unsigned pixel coordinate
//   i_org_x/i_org_y   : signed 12-bit box origin (top-left)
//   i_width/i_height  : box size in pixels
//   o_hit             : pixel lies inside the box
module box_hit (
    input  logic [10:0]        i_pix_x,
    input  logic [9:0]         i_pix_y,
    input  logic signed [11:0] i_org_x,
    input  logic signed [11:0] i_org_y,
    input  logic [11:0]        i_width,
    input  logic [11:0]        i_height,
    output logic               o_hit
);
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;

    // Pixel coordinates are non-negative, origins may be off-screen on either side;
    // the 12-bit difference covers every reachable case without wrapping into range.
    assign w_dx = $signed({1'b0, i_pix_x}) - i_org_x;
    assign w_dy = $signed({2'b00, i_pix_y}) - i_org_y;

    assign o_hit = !w_dx[11] && !w_dy[11] &&
                   (12'(w_dx) < i_width) && (12'(w_dy) < i_height);
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: snapshots the game controller outputs at frame start and turns
// each VGA coordinate into an RGB value with fixed layer priority, 2 cycles later.
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_frame_start      : loads the snapshot (pixel in the same cycle uses the old one)
//   pix                : pixel stream bundle (coordinate in, RGB/layer out)
//   i_state, i_player_*, i_enemy_*, i_goodbullet_*, i_badbullet_* : game inputs
// Build option: define HUD_HP_BAR_EN to draw HP bars (layer 1) in PLAY state.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned CHAR_W   = 64,
    parameter int unsigned CHAR_H   = 96,
    parameter int unsigned BULLET_W = 16,
    parameter int unsigned BULLET_H = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_frame_start,
    sprite_compositor_if.slave  pix,
    input  logic [1:0]          i_state,
    input  logic [10:0]         i_player_x,
    input  logic [9:0]          i_player_y,
    input  logic [1:0]          i_player_hp,
    input  logic                i_player_shield,
    input  logic                i_player_squat,
    input  logic [10:0]         i_enemy_x,
    input  logic [9:0]          i_enemy_y,
    input  logic [1:0]          i_enemy_hp,
    input  logic                i_enemy_shield,
    input  logic                i_enemy_squat,
    input  logic [10:0]         i_goodbullet_x,
    input  logic [9:0]          i_goodbullet_y,
    input  logic                i_goodbullet_isE,
    input  logic [10:0]         i_badbullet_x,
    input  logic [9:0]          i_badbullet_y,
    input  logic                i_badbullet_isE
);
    localparam logic [11:0] BOX_W     = 12'(CHAR_W);
    localparam logic [11:0] FULL_H    = 12'(CHAR_H);
    localparam logic [11:0] SQUAT_OFS = 12'(CHAR_H / 2);
    localparam logic [11:0] SQUAT_H   = 12'(CHAR_H - CHAR_H / 2);
    localparam logic [11:0] INSET     = 12'(SHIELD_T);
    localparam logic [11:0] INSET2    = 12'(2 * SHIELD_T);

    // ---------------- snapshot ----------------
    snapshot_t r_snap;
    snapshot_t w_snap_in;

    always_comb begin
        w_snap_in              = '0;
        w_snap_in.state        = game_state_e'(i_state);
        w_snap_in.player.x     = i_player_x;
        w_snap_in.player.y     = i_player_y;
        w_snap_in.player.hp    = i_player_hp;
        w_snap_in.player.shield = i_player_shield;
        w_snap_in.player.squat = i_player_squat;
        w_snap_in.enemy.x      = i_enemy_x;
        w_snap_in.enemy.y      = i_enemy_y;
        w_snap_in.enemy.hp     = i_enemy_hp;
        w_snap_in.enemy.shield = i_enemy_shield;
        w_snap_in.enemy.squat  = i_enemy_squat;
        w_snap_in.good.x       = i_goodbullet_x;
        w_snap_in.good.y       = i_goodbullet_y;
        w_snap_in.good.ise     = i_goodbullet_isE;
        w_snap_in.bad.x        = i_badbullet_x;
        w_snap_in.bad.y        = i_badbullet_y;
        w_snap_in.bad.ise      = i_badbullet_isE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (i_frame_start) begin
            r_snap <= w_snap_in;
        end
    end

    // ---------------- box geometry ----------------
    logic signed [11:0] w_p_ox, w_p_oy, w_e_ox, w_e_oy;
    logic signed [11:0] w_pi_ox, w_pi_oy, w_ei_ox, w_ei_oy;
    logic [11:0]        w_p_h, w_e_h, w_pi_h, w_ei_h;

    // A squatting character keeps its feet: only the lower half of the box remains.
    always_comb begin
        w_p_ox  = sext_x(r_snap.player.x);
        w_p_oy  = sext_y(r_snap.player.y) + (r_snap.player.squat ? SQUAT_OFS : 12'd0);
        w_p_h   = r_snap.player.squat ? SQUAT_H : FULL_H;
        w_e_ox  = sext_x(r_snap.enemy.x);
        w_e_oy  = sext_y(r_snap.enemy.y) + (r_snap.enemy.squat ? SQUAT_OFS : 12'd0);
        w_e_h   = r_snap.enemy.squat ? SQUAT_H : FULL_H;
        w_pi_ox = w_p_ox + INSET;
        w_pi_oy = w_p_oy + INSET;
        w_pi_h  = w_p_h - INSET2;
        w_ei_ox = w_e_ox + INSET;
        w_ei_oy = w_e_oy + INSET;
        w_ei_h  = w_e_h - INSET2;
    end

    logic w_p_out, w_p_in, w_e_out, w_e_in, w_good_hit, w_bad_hit;

    box_hit u_player_box (
        .i_pix_x(pix.i_pix_x), .i_pix_y(pix.i_pix_y), .i_org_x(w_p_ox), .i_org_y(w_p_oy),
        .i_width(BOX_W), .i_height(w_p_h), .o_hit(w_p_out)
    );
    box_hit u_player_inner (
        .i_pix_x(pix.i_pix_x), .i_pix_y(pix.i_pix_y), .i_org_x(w_pi_ox), .i_org_y(w_pi_oy),
        .i_width(BOX_W - INSET2), .i_height(w_pi_h), .o_hit(w_p_in)
    );
    box_hit u_enemy_box (
        .i_pix_x(pix.i_pix_x), .i_pix_y(pix.i_pix_y), .i_org_x(w_e_ox), .i_org_y(w_e_oy),
        .i_width(BOX_W), .i_height(w_e_h), .o_hit(w_e_out)
    );
    box_hit u_enemy_inner (
        .i_pix_x(pix.i_pix_x), .i_pix_y(pix.i_pix_y), .i_org_x(w_ei_ox), .i_org_y(w_ei_oy),
        .i_width(BOX_W - INSET2), .i_height(w_ei_h), .o_hit(w_e_in)
    );
    box_hit u_good_box (
        .i_pix_x(pix.i_pix_x), .i_pix_y(pix.i_pix_y),
        .i_org_x(sext_x(r_snap.good.x)), .i_org_y(sext_y(r_snap.good.y)),
        .i_width(12'(BULLET_W)), .i_height(12'(BULLET_H)), .o_hit(w_good_hit)
    );
    box_hit u_bad_box (
        .i_pix_x(pix.i_pix_x), .i_pix_y(pix.i_pix_y),
        .i_org_x(sext_x(r_snap.bad.x)), .i_org_y(sext_y(r_snap.bad.y)),
        .i_width(12'(BULLET_W)), .i_height(12'(BULLET_H)), .o_hit(w_bad_hit)
    );

    logic w_shield_hit;
    assign w_shield_hit = (r_snap.player.shield && w_p_out && !w_p_in) ||
                          (r_snap.enemy.shield && w_e_out && !w_e_in);

`ifdef HUD_HP_BAR_EN
    logic        w_hud_p, w_hud_e;
    logic [11:0] w_px12, w_hud_p_hi, w_hud_e_lo;

    // hp=0 gives an empty interval, so no bar is drawn.
    always_comb begin
        w_px12     = {1'b0, pix.i_pix_x};
        w_hud_p_hi = 12'd16 + {5'd0, r_snap.player.hp, 5'd0};
        w_hud_e_lo = 12'(SCREEN_W - 16) - {5'd0, r_snap.enemy.hp, 5'd0};
        w_hud_p    = (pix.i_pix_y >= 10'd8) && (pix.i_pix_y <= 10'd15) &&
                     (w_px12 >= 12'd16) && (w_px12 < w_hud_p_hi);
        w_hud_e    = (pix.i_pix_y >= 10'd8) && (pix.i_pix_y <= 10'd15) &&
                     (w_px12 >= w_hud_e_lo) && (w_px12 < 12'(SCREEN_W - 16));
    end
`else
    logic w_unused_hp;
    assign w_unused_hp = ^{r_snap.player.hp, r_snap.enemy.hp};
`endif

    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(SCREEN_W), 32'(SCREEN_H)};

    // ---------------- stage 1: hit flags ----------------
    logic        r_s1_valid, r_s1_good, r_s1_bad, r_s1_shield, r_s1_player, r_s1_enemy;
    game_state_e r_s1_state;
`ifdef HUD_HP_BAR_EN
    logic        r_s1_hud_p, r_s1_hud_e;
`endif

    // State travels with the pixel so a same-cycle frame_start cannot retint it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_state  <= StStart;
            r_s1_good   <= 1'b0;
            r_s1_bad    <= 1'b0;
            r_s1_shield <= 1'b0;
            r_s1_player <= 1'b0;
            r_s1_enemy  <= 1'b0;
`ifdef HUD_HP_BAR_EN
            r_s1_hud_p  <= 1'b0;
            r_s1_hud_e  <= 1'b0;
`endif
        end else begin
            r_s1_valid  <= pix.i_pix_valid;
            r_s1_state  <= r_snap.state;
            r_s1_good   <= w_good_hit && r_snap.good.ise;
            r_s1_bad    <= w_bad_hit && r_snap.bad.ise;
            r_s1_shield <= w_shield_hit;
            r_s1_player <= w_p_out;
            r_s1_enemy  <= w_e_out;
`ifdef HUD_HP_BAR_EN
            r_s1_hud_p  <= w_hud_p;
            r_s1_hud_e  <= w_hud_e;
`endif
        end
    end

    // ---------------- stage 2: priority resolve ----------------
    logic [23:0] w_rgb;
    layer_e      w_layer;

    always_comb begin
        w_rgb   = 24'd0;
        w_layer = LayerBg;
        if (r_s1_valid) begin
            case (r_s1_state)
                StStart: w_rgb = COL_START;
                StWin:   w_rgb = COL_WIN;
                StLose:  w_rgb = COL_LOSE;
                default: begin
                    w_rgb = COL_BG;
                    if (r_s1_good) begin
                        w_rgb = COL_GOOD;   w_layer = LayerGoodBullet;
                    end else if (r_s1_bad) begin
                        w_rgb = COL_BAD;    w_layer = LayerBadBullet;
                    end else if (r_s1_shield) begin
                        w_rgb = COL_SHIELD; w_layer = LayerShield;
                    end else if (r_s1_player) begin
                        w_rgb = COL_PLAYER; w_layer = LayerPlayer;
                    end else if (r_s1_enemy) begin
                        w_rgb = COL_ENEMY;  w_layer = LayerEnemy;
`ifdef HUD_HP_BAR_EN
                    end else if (r_s1_hud_p) begin
                        w_rgb = COL_HUD_P;  w_layer = LayerHud;
                    end else if (r_s1_hud_e) begin
                        w_rgb = COL_HUD_E;  w_layer = LayerHud;
`endif
                    end
                end
            endcase
        end
    end

    logic        r_valid;
    logic [23:0] r_rgb;
    layer_e      r_layer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rgb   <= 24'd0;
            r_layer <= LayerBg;
        end else begin
            r_valid <= r_s1_valid;
            r_rgb   <= w_rgb;
            r_layer <= w_layer;
        end
    end

    assign pix.o_valid = r_valid;
    assign pix.o_r     = r_rgb[23:16];
    assign pix.o_g     = r_rgb[15:8];
    assign pix.o_b     = r_rgb[7:0];
    assign pix.o_layer = r_layer;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a table of scene/pixel vectors with
// hand-computed colours, plus sequences for snapshot timing, reset and streaming.
module tb_sprite_compositor;

    localparam logic [23:0] C_START = 24'h0000C0, C_WIN = 24'h00C000, C_LOSE = 24'hC00000;
    localparam logic [23:0] C_BG = 24'h202020, C_PL = 24'h2060FF, C_EN = 24'hFF4020;
    localparam logic [23:0] C_SH = 24'h00FFFF, C_GOOD = 24'hFFFF00, C_BAD = 24'hFF00FF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic [1:0] state = 2'd0;
    logic [10:0] player_x = '0, enemy_x = '0, good_x = '0, bad_x = '0;
    logic [9:0] player_y = '0, enemy_y = '0, good_y = '0, bad_y = '0;
    logic [1:0] player_hp = '0, enemy_hp = '0;
    logic player_shield = 1'b0, enemy_shield = 1'b0, player_squat = 1'b0, enemy_squat = 1'b0;
    logic good_e = 1'b0, bad_e = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sprite_compositor_if u_if ();

    sprite_compositor u_dut (
        .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start), .pix(u_if),
        .i_state(state),
        .i_player_x(player_x), .i_player_y(player_y), .i_player_hp(player_hp),
        .i_player_shield(player_shield), .i_player_squat(player_squat),
        .i_enemy_x(enemy_x), .i_enemy_y(enemy_y), .i_enemy_hp(enemy_hp),
        .i_enemy_shield(enemy_shield), .i_enemy_squat(enemy_squat),
        .i_goodbullet_x(good_x), .i_goodbullet_y(good_y), .i_goodbullet_isE(good_e),
        .i_badbullet_x(bad_x), .i_badbullet_y(bad_y), .i_badbullet_isE(bad_e)
    );

    typedef struct {
        logic [1:0]  st;
        logic [10:0] px;  logic [9:0] py;  logic sq;  logic sh;
        logic [1:0]  php; logic [1:0] ehp;
        logic [10:0] gx;  logic [9:0] gy;  logic ge;
        logic [10:0] bx;  logic [9:0] by;  logic be;
        logic [10:0] x;   logic [9:0] y;
        logic [23:0] rgb; logic [2:0] layer;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int st, input int px, input int py, input int sq,
                                input int sh, input int php, input int ehp,
                                input int gx, input int gy, input int ge,
                                input int bx, input int by, input int be,
                                input int x, input int y, input logic [23:0] rgb,
                                input int layer);
        vec_t v;
        v.st = 2'(st);   v.px = 11'(px); v.py = 10'(py); v.sq = 1'(sq); v.sh = 1'(sh);
        v.php = 2'(php); v.ehp = 2'(ehp);
        v.gx = 11'(gx);  v.gy = 10'(gy); v.ge = 1'(ge);
        v.bx = 11'(bx);  v.by = 10'(by); v.be = 1'(be);
        v.x = 11'(x);    v.y = 10'(y);   v.rgb = rgb; v.layer = 3'(layer);
        return v;
    endfunction

    task automatic check(input string nm, input logic v, input logic [23:0] rgb,
                         input logic [2:0] ly, input bit chk_layer);
        logic [23:0] got;
        got = {u_if.o_r, u_if.o_g, u_if.o_b};
        n_checks++;
        if (u_if.o_valid !== v || got !== rgb || (chk_layer && u_if.o_layer !== ly)) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b rgb=%06h layer=%0d, expected valid=%0b rgb=%06h layer=%0d",
                     nm, u_if.o_valid, got, u_if.o_layer, v, rgb, ly);
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Enemy is parked at (300,100) with shield up in every scene.
    task automatic set_scene(input vec_t v);
        state = v.st;
        player_x = v.px; player_y = v.py; player_squat = v.sq; player_shield = v.sh;
        player_hp = v.php; enemy_hp = v.ehp;
        enemy_x = 11'd300; enemy_y = 10'd100; enemy_shield = 1'b1; enemy_squat = 1'b0;
        good_x = v.gx; good_y = v.gy; good_e = v.ge;
        bad_x = v.bx; bad_y = v.by; bad_e = v.be;
        frame();
    endtask

    task automatic send_pix(input int x, input int y);
        u_if.i_pix_valid = 1'b1;
        u_if.i_pix_x = 11'(x);
        u_if.i_pix_y = 10'(y);
        @(posedge clk); #1;
        u_if.i_pix_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t sc;
        u_if.i_pix_valid = 1'b0;
        u_if.i_pix_x = '0;
        u_if.i_pix_y = '0;

        //          st  px   py  sq sh php ehp  gx   gy  ge  bx   by  be   x    y   rgb     layer
        vecs.push_back(mk(0, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0,   0,   0, C_START, 0));
        vecs.push_back(mk(2, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0,   5,   5, C_WIN,   0));
        vecs.push_back(mk(3, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 100, 200, C_LOSE,  0));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 100, 200, C_PL,    3));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 163, 295, C_PL,    3));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 164, 200, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 100, 296, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 1, 0, 0, 0,    0,   0, 0,   0,   0, 0, 120, 220, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 1, 0, 0, 0,    0,   0, 0,   0,   0, 0, 120, 250, C_PL,    3));
        vecs.push_back(mk(1, 100, 200, 1, 1, 0, 0,    0,   0, 0,   0,   0, 0, 101, 250, C_SH,    4));
        vecs.push_back(mk(1, 100, 200, 0, 1, 0, 0,    0,   0, 0,   0,   0, 0, 120, 230, C_PL,    3));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,  110, 210, 1,   0,   0, 0, 112, 212, C_GOOD,  6));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,   -8, 210, 1,   0,   0, 0,   0, 210, C_GOOD,  6));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,   -8, 210, 1,   0,   0, 0, 639, 210, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,  110, 210, 0,   0,   0, 0, 112, 212, C_PL,    3));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0, 100, 200, 1, 100, 200, C_BAD,   5));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,  100, 200, 1, 100, 200, 1, 100, 200, C_GOOD,  6));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 300, 100, C_SH,    4));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 310, 110, C_EN,    2));
        vecs.push_back(mk(1, -30, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0,   0, 200, C_PL,    3));
        vecs.push_back(mk(1, -30, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0, 639, 200, C_BG,    0));
`ifdef HUD_HP_BAR_EN
        vecs.push_back(mk(1, 100, 200, 0, 0, 2, 1,    0,   0, 0,   0,   0, 0,  79,  10, 24'h00FF00, 1));
        vecs.push_back(mk(1, 100, 200, 0, 0, 2, 1,    0,   0, 0,   0,   0, 0,  80,  10, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 0, 0, 2, 1,    0,   0, 0,   0,   0, 0, 600,  12, 24'hFF0000, 1));
        vecs.push_back(mk(1, 100, 200, 0, 0, 2, 1,    0,   0, 0,   0,   0, 0, 624,  12, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 0, 0, 0, 0,    0,   0, 0,   0,   0, 0,  20,  10, C_BG,    0));
`else
        vecs.push_back(mk(1, 100, 200, 0, 0, 2, 1,    0,   0, 0,   0,   0, 0,  79,  10, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 0, 0, 2, 1,    0,   0, 0,   0,   0, 0,  20,  10, C_BG,    0));
        vecs.push_back(mk(1, 100, 200, 0, 0, 2, 1,    0,   0, 0,   0,   0, 0, 600,  12, C_BG,    0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 24'd0, 3'd0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            set_scene(vecs[i]);
            send_pix(int'(vecs[i].x), int'(vecs[i].y));
            check($sformatf("vec%0d", i), 1'b1, vecs[i].rgb, vecs[i].layer, 1'b1);
        end

        // Invalid pixel inside the player: RGB forced to zero
        sc = mk(1, 100, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_PL, 3);
        set_scene(sc);
        u_if.i_pix_x = 11'd100;
        u_if.i_pix_y = 10'd200;
        u_if.i_pix_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("invalid_pix", 1'b0, 24'd0, 3'd0, 1'b0);

        // Mid-frame input change is ignored until the next frame_start
        player_x = 11'd400;
        send_pix(100, 200);
        check("midframe_hold_old", 1'b1, C_PL, 3'd3, 1'b1);
        send_pix(400, 200);
        check("midframe_new_absent", 1'b1, C_BG, 3'd0, 1'b1);
        frame();
        send_pix(400, 200);
        check("after_frame_new", 1'b1, C_PL, 3'd3, 1'b1);
        send_pix(100, 200);
        check("after_frame_old_gone", 1'b1, C_BG, 3'd0, 1'b1);

        // frame_start and pixel in the same cycle: pixel sees the old snapshot
        player_x = 11'd100;
        frame_start = 1'b1;
        u_if.i_pix_valid = 1'b1;
        u_if.i_pix_x = 11'd100;
        u_if.i_pix_y = 10'd200;
        @(posedge clk); #1;
        frame_start = 1'b0;
        u_if.i_pix_valid = 1'b0;
        @(posedge clk); #1;
        check("same_cycle_old", 1'b1, C_BG, 3'd0, 1'b1);
        send_pix(100, 200);
        check("same_cycle_new", 1'b1, C_PL, 3'd3, 1'b1);

        // Back-to-back pixels, one result per cycle
        u_if.i_pix_valid = 1'b1;
        u_if.i_pix_x = 11'd100; u_if.i_pix_y = 10'd200;
        @(posedge clk); #1;
        u_if.i_pix_x = 11'd164; u_if.i_pix_y = 10'd200;
        @(posedge clk); #1;
        u_if.i_pix_x = 11'd310; u_if.i_pix_y = 10'd110;
        check("stream0", 1'b1, C_PL, 3'd3, 1'b1);
        @(posedge clk); #1;
        u_if.i_pix_valid = 1'b0;
        check("stream1", 1'b1, C_BG, 3'd0, 1'b1);
        @(posedge clk); #1;
        check("stream2", 1'b1, C_EN, 3'd2, 1'b1);

        // Reset mid-frame: outputs drop at once, then START colour until frame_start
        send_pix(100, 200);
        check("pre_reset", 1'b1, C_PL, 3'd3, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_midframe", 1'b0, 24'd0, 3'd0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_pix(100, 200);
        check("after_reset_start", 1'b1, C_START, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
